// File: rtl/sigmoid_backward.sv
// sigmoid_backward
//   Streaming backward pass of a sigmoid layer: dx = g * y * (1 - y).
//   y (unsigned Q8.8, stored forward output) and g (signed Q8.8, upstream
//   gradient) enter together; dx leaves three cycles later. Valid/ready on
//   both sides, a last flag for framing, and per-frame element counting.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational)
//   in_y, in_grad     forward output y, upstream gradient g
//   in_last           final element of a frame
//   out_valid/ready   output handshake
//   out_grad, out_last  dx and its delayed last flag
//   elem_count        output handshakes so far in the current frame
//   frame_len         element count of the most recently completed frame
//   frame_done        one-cycle pulse after the last handshake of a frame
module sigmoid_backward #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [DATA_WIDTH-1:0] in_grad,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_grad,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  elem_count,
    output logic [CNT_WIDTH-1:0]  frame_len,
    output logic                  frame_done
);

    // y*(1-y) peaks at 0.25, so the floored product needs FRACT_WIDTH-1 bits.
    localparam int YW  = FRACT_WIDTH + 1;
    localparam int DW  = 2 * YW;
    localparam int D8W = FRACT_WIDTH - 1;
    localparam int PW  = DATA_WIDTH + D8W + 1;

    localparam logic [YW-1:0] ONE = {1'b1, {FRACT_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE_WIDE = {{(DATA_WIDTH-YW){1'b0}}, ONE};
    localparam logic signed [PW-1:0] HALF =
        {{(PW-FRACT_WIDTH){1'b0}}, 1'b1, {(FRACT_WIDTH-1){1'b0}}};

    logic en;
    logic hs;

    // stage 1
    logic                  v1;
    logic [YW-1:0]         yc1;
    logic [YW-1:0]         om1;
    logic [DATA_WIDTH-1:0] g1;
    logic                  l1;

    // stage 2
    logic                  v2;
    logic [D8W-1:0]        d8_2;
    logic [DATA_WIDTH-1:0] g2;
    logic                  l2;

    // stage 3 is the output register
    logic                  v3;

    // combinational stage inputs
    logic [YW-1:0]         yc_c;
    logic [YW-1:0]         om_c;
    logic [DW-1:0]         d_c;
    logic [D8W-1:0]        d8_c;
    logic signed [PW-1:0]  pa_c;
    logic signed [PW-1:0]  pb_c;
    logic signed [PW-1:0]  p_c;
    logic signed [PW-1:0]  r_c;

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;
    assign hs        = v3 && out_ready;

    always_comb begin
        yc_c = ONE;
        if (in_y <= ONE_WIDE) begin
            yc_c = YW'(in_y);
        end
        om_c = ONE - yc_c;
    end

    always_comb begin
        d_c  = {{YW{1'b0}}, yc1} * {{YW{1'b0}}, om1};
        d8_c = D8W'(d_c >> FRACT_WIDTH);
    end

    // Signed gradient times non-negative d8; adding half an LSB before the
    // arithmetic shift rounds ties toward +inf.
    always_comb begin
        pa_c = {{(D8W+1){g2[DATA_WIDTH-1]}}, g2};
        pb_c = {{(DATA_WIDTH+1){1'b0}}, d8_2};
        p_c  = pa_c * pb_c;
        r_c  = (p_c + HALF) >>> FRACT_WIDTH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            yc1      <= '0;
            om1      <= '0;
            g1       <= '0;
            l1       <= 1'b0;
            d8_2     <= '0;
            g2       <= '0;
            l2       <= 1'b0;
            out_grad <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                yc1 <= yc_c;
                om1 <= om_c;
                g1  <= in_grad;
                l1  <= in_last;
            end
            if (v1) begin
                d8_2 <= d8_c;
                g2   <= g1;
                l2   <= l1;
            end
            // Output data only changes when a real element arrives, so it
            // holds across bubbles as well as stalls.
            if (v2) begin
                out_grad <= DATA_WIDTH'(r_c);
                out_last <= l2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            elem_count <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (hs) begin
                if (out_last) begin
                    frame_len  <= elem_count + CNT_WIDTH'(1);
                    elem_count <= '0;
                    frame_done <= 1'b1;
                end else begin
                    elem_count <= elem_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_backward.sv
// tb_sigmoid_backward
//   Self-checking bench for sigmoid_backward. Expected dx values come from a
//   plain-integer reference function and flow through an in-order queue;
//   frame counters are tracked by a small scoreboard. The counter width is
//   reduced so that a frame longer than the counter range fits in a short run.
module tb_sigmoid_backward;

    localparam int DW   = 16;
    localparam int CW   = 10;
    localparam int CMASK = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_y;
    logic [DW-1:0] in_grad;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_grad;
    logic          out_last;
    logic [CW-1:0] elem_count;
    logic [CW-1:0] frame_len;
    logic          frame_done;

    sigmoid_backward #(
        .DATA_WIDTH (DW),
        .FRACT_WIDTH(8),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_grad   (in_grad),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_grad  (out_grad),
        .out_last  (out_last),
        .elem_count(elem_count),
        .frame_len (frame_len),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dx;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   m_elem;
    int   m_flen;
    logic m_done;
    int   done_seen;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // dx = round(g * floor(yc*(1-yc)) ), yc = min(y, 1.0), in plain integers.
    function automatic logic [DW-1:0] ref_dx(input logic [DW-1:0] y, input logic [DW-1:0] g);
        int yc, d8, p, r;
        yc = (y > 16'h0100) ? 256 : int'(y);
        d8 = (yc * (256 - yc)) / 256;
        p  = int'($signed(g)) * d8;
        r  = (p + 128) >>> 8;
        return r[DW-1:0];
    endfunction

    // One clock cycle, entered just after a falling edge.
    task automatic cyc(input logic iv, input logic [DW-1:0] y, input logic [DW-1:0] g,
                       input logic l, input logic ordy,
                       output logic acc, output logic ov, output logic ir);
        logic ohs;
        in_valid  = iv;
        in_y      = y;
        in_grad   = g;
        in_last   = l;
        out_ready = ordy;
        #1;
        ov  = out_valid;
        ir  = in_ready;
        acc = iv & in_ready;
        ohs = out_valid & ordy;
        m_done = 1'b0;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                check("out_grad", {16'd0, out_grad}, {16'd0, q[0].dx});
                check("out_last", {31'd0, out_last}, {31'd0, q[0].last});
                if (ohs) begin
                    if (q[0].last) begin
                        m_flen = (m_elem + 1) & CMASK;
                        m_elem = 0;
                        m_done = 1'b1;
                    end else begin
                        m_elem = (m_elem + 1) & CMASK;
                    end
                    void'(q.pop_front());
                end
            end
        end
        if (acc) q.push_back('{ref_dx(y, g), l});
        @(negedge clk);
        if (frame_done === 1'b1) done_seen++;
        check("elem_count", {22'd0, elem_count}, m_elem);
        check("frame_len", {22'd0, frame_len}, m_flen);
        check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_elem = 0;
        m_flen = 0;
        m_done = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_grad", {16'd0, out_grad}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_elem_count", {22'd0, elem_count}, 32'd0);
        check("rst_frame_len", {22'd0, frame_len}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drain(input string tag);
        logic a, o, r;
        for (int k = 0; k < 50 && q.size() > 0; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1, a, o, r);
        check(tag, q.size(), 32'd0);
    endtask

    // Feeds n elements with out_ready high, last flag on the final one.
    task automatic send_frame(input int n);
        logic a, o, r;
        int sent;
        logic [DW-1:0] y, g;
        sent = 0;
        y = 16'($urandom_range(0, 300));
        g = 16'($urandom);
        for (int k = 0; k < 4 * n + 10 && sent < n; k++) begin
            cyc(1'b1, y, g, (sent == n - 1), 1'b1, a, o, r);
            if (a) begin
                sent++;
                y = 16'($urandom_range(0, 300));
                g = 16'($urandom);
            end
        end
        check("send_frame_count", sent, n);
    endtask

    initial begin
        logic a, o, r;
        int lat, c, i, d0;
        logic [DW-1:0] ys[8];
        logic [DW-1:0] gs[8];
        int sent, remaining;
        logic pend, pl, long_done;
        logic [DW-1:0] py, pg;

        n_tests = 0; n_fail = 0; done_seen = 0;
        m_elem = 0; m_flen = 0; m_done = 1'b0;
        reset = 1'b1; in_valid = 1'b0; in_y = '0; in_grad = '0; in_last = 1'b0; out_ready = 1'b0;
        do_reset();

        // 1: basic value and latency
        cyc(1'b1, 16'h0080, 16'h0100, 1'b1, 1'b1, a, o, r);
        check("t1_accept", {31'd0, a}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, a, o, r);
            if (o) lat = k;
        end
        check("t1_latency", lat, 32'd3);
        check("t1_ref", {16'd0, ref_dx(16'h0080, 16'h0100)}, 32'h40);
        drain("t1_drain");

        // 2: negative gradient, y at 0, 1.0 and above 1.0
        check("t2_ref_neg", {16'd0, ref_dx(16'h0040, 16'hFF00)}, 32'hFFD0);
        cyc(1'b1, 16'h0040, 16'hFF00, 1'b0, 1'b1, a, o, r);
        cyc(1'b1, 16'h0000, 16'h7FFF, 1'b0, 1'b1, a, o, r);
        cyc(1'b1, 16'h0100, 16'h7FFF, 1'b0, 1'b1, a, o, r);
        cyc(1'b1, 16'h0180, 16'h7FFF, 1'b1, 1'b1, a, o, r);
        drain("t2_drain");

        // 3: 8 back-to-back elements with a 4-cycle output stall
        foreach (ys[k]) begin
            ys[k] = 16'($urandom_range(0, 400));
            gs[k] = 16'($urandom);
        end
        i = 0;
        for (c = 0; c < 40 && (i < 8 || q.size() > 0); c++) begin
            cyc((i < 8), ys[i % 8], gs[i % 8], (i == 7), !(c >= 4 && c < 8), a, o, r);
            if (c < 12) check("t3_in_ready", {31'd0, r}, (c >= 4 && c < 8) ? 32'd0 : 32'd1);
            if (a) i++;
        end
        check("t3_sent", i, 32'd8);
        check("t3_drain", q.size(), 32'd0);

        // 4: 5-element frame then a 1-element frame
        d0 = done_seen;
        send_frame(5);
        drain("t4_drain5");
        check("t4_done_pulses", done_seen - d0, 32'd1);
        check("t4_frame_len5", {22'd0, frame_len}, 32'd5);
        check("t4_elem_count", {22'd0, elem_count}, 32'd0);
        send_frame(1);
        drain("t4_drain1");
        check("t4_frame_len1", {22'd0, frame_len}, 32'd1);

        // 5: reset with 3 elements in flight and the output stalled
        send_frame(2);
        drain("t5_predrain");
        for (int k = 0; k < 3; k++) cyc(1'b1, 16'h0080, 16'h0100, 1'b0, 1'b0, a, o, r);
        do_reset();
        d0 = done_seen;
        for (int k = 0; k < 8; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1, a, o, r);
        check("t5_no_done", done_seen - d0, 32'd0);

        // 6: random traffic with random framing, including one long frame
        sent = 0;
        remaining = $urandom_range(1, 20);
        pend = 1'b0; pl = 1'b0; long_done = 1'b0;
        py = '0; pg = '0;
        for (c = 0; c < 60000 && sent < 10000; c++) begin
            if (!pend && ($urandom % 4 != 0)) begin
                pend = 1'b1;
                py = ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 256));
                pg = 16'($urandom);
                pl = (remaining == 1);
            end
            cyc(pend, py, pg, pl, ($urandom % 4 != 0), a, o, r);
            if (a) begin
                pend = 1'b0;
                sent++;
                remaining--;
                if (remaining == 0) begin
                    if (!long_done && sent >= 3000) begin
                        remaining = 1100;
                        long_done = 1'b1;
                    end else begin
                        remaining = $urandom_range(1, 20);
                    end
                end
            end
        end
        check("t6_sent", sent, 32'd10000);
        check("t6_long_frame", {31'd0, long_done}, 32'd1);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
